// File: rtl/safe_dial_pkg.sv
// Shared types and helpers for the safe dial sequencer.
package safe_dial_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StReduce = 2'd1,
    StApply  = 2'd2,
    StDone   = 2'd3
  } seq_state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Width needed to hold a dial position 0..dial_size-1.
  function automatic int unsigned pos_width(input int unsigned dial_size);
    return $clog2(dial_size);
  endfunction

endpackage

// File: rtl/safe_dial_step.sv
// Combinational single-rotation step: applies a reduced distance (< DIAL_SIZE)
// to the current position and reports landing on and crossing through zero.
module safe_dial_step
  import safe_dial_pkg::*;
#(
  parameter int unsigned DIAL_SIZE = 100
) (
  input  logic [pos_width(DIAL_SIZE)-1:0] pos_i,
  input  logic [pos_width(DIAL_SIZE)-1:0] r_i,
  input  logic                            dir_i,
  output logic [pos_width(DIAL_SIZE)-1:0] new_pos_o,
  output logic                            landed_o,
  output logic                            crossed_o
);

  localparam int unsigned PosWidth = pos_width(DIAL_SIZE);

  // One extra bit so pos+r and pos+DIAL_SIZE never overflow.
  localparam logic [PosWidth:0] DialSizeW = (PosWidth + 1)'(DIAL_SIZE);

  logic [PosWidth:0] pos_w;
  logic [PosWidth:0] r_w;
  logic [PosWidth:0] wide;

  // Wrap-around arithmetic and zero-crossing detection for one rotation.
  always_comb begin
    pos_w     = {1'b0, pos_i};
    r_w       = {1'b0, r_i};
    wide      = '0;
    crossed_o = 1'b0;
    if (dir_i == DIR_RIGHT) begin
      wide = pos_w + r_w;
      if (wide >= DialSizeW) begin
        wide      = wide - DialSizeW;
        crossed_o = 1'b1;
      end
    end else begin
      if (r_w > pos_w) begin
        wide = pos_w + DialSizeW - r_w;
      end else begin
        wide = pos_w - r_w;
      end
      // Starting on zero is not a pass; reaching or going past zero is.
      crossed_o = (r_i != '0) && (pos_i != '0) && (r_w >= pos_w);
    end
    new_pos_o = wide[PosWidth-1:0];
    landed_o  = (new_pos_o == '0);
  end

endmodule

// File: rtl/safe_dial_sequencer.sv
// Accepts dial rotation commands, reduces large distances one revolution per
// cycle, then applies the remainder and updates land/hit counters.
module safe_dial_sequencer
  import safe_dial_pkg::*;
#(
  parameter int unsigned DIAL_SIZE  = 100,
  parameter int unsigned DIAL_START = 50,
  parameter int unsigned DIST_WIDTH = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            cmd_valid_i,
  output logic                            cmd_ready_o,
  input  logic                            cmd_direction_i,
  input  logic [DIST_WIDTH-1:0]           cmd_distance_i,
  input  logic                            cmd_last_i,
  output logic [pos_width(DIAL_SIZE)-1:0] position_o,
  output logic [31:0]                     land_count_o,
  output logic [31:0]                     hit_count_o,
  output logic                            busy_o,
  output logic                            done_o
);

  localparam int unsigned PosWidth = pos_width(DIAL_SIZE);

  localparam logic [DIST_WIDTH:0]   DialSizeD = (DIST_WIDTH + 1)'(DIAL_SIZE);
  localparam logic [PosWidth-1:0]   StartPos  = PosWidth'(DIAL_START);

  seq_state_e            state_q, state_d;
  logic                  dir_q, dir_d;
  logic                  last_q, last_d;
  logic [DIST_WIDTH-1:0] rem_q, rem_d;
  logic [PosWidth-1:0]   pos_q, pos_d;
  logic [31:0]           land_q, land_d;
  logic [31:0]           hit_q, hit_d;

  logic                  rem_ge;
  logic [PosWidth-1:0]   step_pos;
  logic                  step_landed;
  logic                  step_crossed;

  assign rem_ge = ({1'b0, rem_q} >= DialSizeD);

  // rem_q is already below DIAL_SIZE whenever the step result is consumed.
  safe_dial_step #(
    .DIAL_SIZE (DIAL_SIZE)
  ) u_step (
    .pos_i     (pos_q),
    .r_i       (PosWidth'(rem_q)),
    .dir_i     (dir_q),
    .new_pos_o (step_pos),
    .landed_o  (step_landed),
    .crossed_o (step_crossed)
  );

  // Next-state logic: accept, reduce by whole revolutions, apply, finish.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    last_d  = last_q;
    rem_d   = rem_q;
    pos_d   = pos_q;
    land_d  = land_q;
    hit_d   = hit_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          dir_d   = cmd_direction_i;
          rem_d   = cmd_distance_i;
          last_d  = cmd_last_i;
          state_d = StReduce;
        end
      end
      StReduce: begin
        if (rem_ge) begin
          // Every full revolution passes zero exactly once.
          rem_d = rem_q - DialSizeD[DIST_WIDTH-1:0];
          hit_d = hit_q + 32'd1;
        end else begin
          state_d = StApply;
        end
      end
      StApply: begin
        pos_d   = step_pos;
        hit_d   = hit_q + 32'(step_crossed);
        land_d  = land_q + 32'(step_landed);
        state_d = last_q ? StDone : StIdle;
      end
      StDone: begin
        // Terminal until reset.
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any in-flight command.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      dir_q   <= DIR_LEFT;
      last_q  <= 1'b0;
      rem_q   <= '0;
      pos_q   <= StartPos;
      land_q  <= '0;
      hit_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      last_q  <= last_d;
      rem_q   <= rem_d;
      pos_q   <= pos_d;
      land_q  <= land_d;
      hit_q   <= hit_d;
    end
  end

  assign cmd_ready_o  = (state_q == StIdle);
  assign busy_o       = (state_q == StReduce) || (state_q == StApply);
  assign done_o       = (state_q == StDone);
  assign position_o   = pos_q;
  assign land_count_o = land_q;
  assign hit_count_o  = hit_q;

endmodule

// File: doc/safe_dial_sequencer.md
Name: safe_dial_sequencer

Overview:
Multi-cycle controller that accepts a stream of dial rotation commands over a valid/ready handshake and sequences each command through a modular-reduction and apply datapath. It reduces large distances by iterative subtraction of DIAL_SIZE instead of a combinational reducer. It tracks two counts: landings on position 0, and every pass through position 0, including full revolutions and partial crossings. It sits between the puzzle-input streamer and the result readout, and signals completion after the command flagged last.

Parameters:
DIAL_SIZE, 100, number of dial positions (2..127)
DIAL_START, 50, position after reset (< DIAL_SIZE)
DIST_WIDTH, 16, width of cmd_distance_i

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous reset, active high
cmd_valid_i  input  1  command valid
cmd_ready_o  output  1  command accepted when valid&&ready at clk edge
cmd_direction_i  input  1  0=Left (decreasing), 1=Right (increasing)
cmd_distance_i  input  DIST_WIDTH  rotation distance, unsigned
cmd_last_i  input  1  marks final command of the stream
position_o  output  $clog2(DIAL_SIZE)  current dial position
land_count_o  output  32  rotations ending on position 0
hit_count_o  output  32  total times the dial points at 0 during or at end of rotations
busy_o  output  1  high in REDUCE/APPLY
done_o  output  1  high after last command applied

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high on rst_i.
- Reset values: state IDLE, position_o=DIAL_START, land_count_o=0, hit_count_o=0, done_o=0, busy_o=0, cmd_ready_o=1 in the first cycle after reset.
- Reset has priority over all other activity, including mid-REDUCE and mid-APPLY. An in-flight command is discarded.
- FSM states: IDLE, REDUCE, APPLY, DONE.
- IDLE:
  - cmd_ready_o=1.
  - On valid&&ready, latch dir, rem=distance and last, then go to REDUCE.
  - cmd_ready_o is combinational from state only.
- REDUCE, one step per cycle:
  - If rem >= DIAL_SIZE: rem -= DIAL_SIZE and hit_count += 1. Each full revolution passes 0 once.
  - Otherwise go to APPLY.
  - Occupies floor(distance/DIAL_SIZE)+1 cycles.
- APPLY, one cycle; pos = position_o, r = rem (< DIAL_SIZE):
  - Right: sum = pos+r. new_pos = sum-DIAL_SIZE if sum >= DIAL_SIZE, else sum. Crossing when sum >= DIAL_SIZE.
  - Left: new_pos = pos-r+DIAL_SIZE if r > pos, else pos-r. Crossing when r > 0 && pos != 0 && r >= pos.
  - hit_count += crossing.
  - land_count += (new_pos == 0). This includes a zero-distance rotation while already at 0; such a rotation adds no hit.
  - Next state is DONE if the latched last=1, else IDLE.
- Latency: position and counters are visible the cycle after the APPLY edge. Total accept-to-update is floor(d/N)+2 edges. Back-to-back commands can be accepted the cycle after APPLY.
- DONE: done_o=1, cmd_ready_o=0, outputs held. Exit only via reset.
- busy_o=1 in REDUCE and APPLY.
- Counters wrap modulo 2^32, with no saturation.
- Internal arithmetic is carried at position width+1 bits to hold pos+r without overflow.
- Inputs are ignored while cmd_ready_o=0. Valid may stay asserted without effect.

Decomposition:
- safe_dial_pkg holds:
  - state enum seq_state_e (IDLE, REDUCE, APPLY, DONE)
  - POS_WIDTH function/constant derived via $clog2(DIAL_SIZE)
  - DIR_LEFT/DIR_RIGHT constants
- One sub-module, safe_dial_step: purely combinational APPLY math.
  - Inputs: pos, r, dir.
  - Outputs: new_pos, landed, crossed.
  - Parameterised by DIAL_SIZE; reusable by the bench model.
- FSM, REDUCE loop and counters live in safe_dial_sequencer.

Test Plan:
- Reset, then L68 (dir=0, d=68) -> REDUCE 1 cycle, APPLY; position_o=82, hit_count_o=1, land_count_o=0, ready high again 3 cycles after accept.
- R1000 from 50 -> REDUCE 11 cycles, busy_o high 12 cycles; position_o=50, hit_count_o=10, land_count_o=0.
- Stream L68 L30 R48 L5 R60 L55 L1 L99 R14 L82, last on L82 -> final position_o=32, land_count_o=3, hit_count_o=6, done_o=1, cmd_ready_o=0 thereafter.
- R50 then L0 -> after R50: position_o=0, land=1, hit=1. After L0: position_o=0, land=2, hit=1.
- R5000 accepted, rst_i asserted on 3rd REDUCE cycle -> next cycle position_o=50, counts 0, busy_o=0, cmd_ready_o=1; subsequent R50 gives position_o=0, land=1, hit=1.
- cmd_valid_i held high with changing data during REDUCE/APPLY -> no extra acceptance. Only the command present while cmd_ready_o=1 is taken; count increments match single-command results exactly.
